// File: rtl/sram_byte_reader_if.sv
// Interface bundling the request, SRAM read port and byte-stream handshake of
// sram_byte_reader. The slave side is the reader itself; the master side is
// whatever drives requests, models the SRAM and consumes bytes.
interface sram_byte_reader_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
);
  // Request side
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_words;
  // SRAM read port
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_raddr;
  logic [127:0]      sram_rdata;
  // Byte stream to the consumer
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic [3:0]        out_offset;
  // Status
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, num_words, sram_rdata, out_ready,
    output sram_rd_en, sram_raddr, out_valid, out_byte, out_offset, busy, done
  );

  modport master (
    output start, base_addr, num_words, sram_rdata, out_ready,
    input  sram_rd_en, sram_raddr, out_valid, out_byte, out_offset, busy, done
  );
endinterface

// File: rtl/sram_byte_reader.sv
// Fetches 128-bit words from the activation SRAM and emits each one as 16
// bytes in position-offset order, using the same offset-to-lane shuffle as the
// byte-lane write path. One byte per valid/ready handshake.
module sram_byte_reader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_byte_reader_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              rd_en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remain_reg;
  logic [127:0]      word_reg;
  logic [3:0]        offset_reg;

  logic              last_accept;
  logic [3:0]        lane_sel;
  logic [7:0]        lane_bytes [16];

  // Byte accepted at the final offset of the current word
  assign last_accept = (state_reg == DRAIN) && bus.out_ready && (offset_reg == 4'd15);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE so a busy reader ignores it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.num_words == '0) ? FIN : REQ;
        end
      end
      REQ:   state_next = WAIT;
      WAIT:  state_next = DRAIN;
      DRAIN: begin
        if (last_accept) begin
          state_next = (remain_reg != '0) ? REQ : FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: request latch, read strobe, word capture and offset stepping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_reg  <= 1'b0;
      addr_reg   <= '0;
      remain_reg <= '0;
      word_reg   <= '0;
      offset_reg <= '0;
    end else begin
      // Read enable is registered straight from the upcoming state so it is
      // high for exactly the single REQ cycle.
      rd_en_reg <= (state_next == REQ);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            addr_reg   <= bus.base_addr;
            remain_reg <= bus.num_words;
          end
        end
        WAIT: begin
          // rdata is valid now, one cycle after the REQ strobe
          word_reg   <= bus.sram_rdata;
          offset_reg <= '0;
          addr_reg   <= addr_reg + ADDR_W'(1);
          remain_reg <= remain_reg - CNT_W'(1);
        end
        DRAIN: begin
          // Wraps 15 -> 0 on the last accept, which is harmless since WAIT reloads it
          if (bus.out_ready) begin
            offset_reg <= offset_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Split the word into lanes, lane 0 being the most significant byte
  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    assign lane_bytes[gi] = word_reg[127 - 8*gi -: 8];
  end

  // The offset-to-lane map is a fixed bit permutation of the offset:
  // lane = {off[2], off[0], off[3], off[1]}
  assign lane_sel = {offset_reg[2], offset_reg[0], offset_reg[3], offset_reg[1]};

  assign bus.sram_rd_en = rd_en_reg;
  assign bus.sram_raddr = addr_reg;
  assign bus.out_valid  = (state_reg == DRAIN);
  assign bus.out_offset = offset_reg;
  assign bus.out_byte   = lane_bytes[lane_sel];
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == FIN);

endmodule

// File: tb/tb_sram_byte_reader.sv
// Randomised self-checking bench for sram_byte_reader. A behavioural SRAM and
// a table-driven byte-order model produce every expected value.
module tb_sram_byte_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_byte_reader_if bus ();

  sram_byte_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: registered read, data valid the cycle after rd_en
  logic [127:0] mem [1024];
  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_rdata <= mem[bus.sram_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  int lane_map [16] = '{0, 4, 1, 5, 8, 12, 9, 13, 2, 6, 3, 7, 10, 14, 11, 15};

  // Observations collected per transaction
  int          rd_addr_q [$];
  int          rd_cyc_q  [$];
  int          rd_acc_q  [$];
  logic [7:0]  byte_q    [$];
  int          off_q     [$];
  int          acc_cyc_q [$];
  int          done_cyc_q[$];
  int          first_valid;
  int          valid_cycles;
  int          stall_viol;

  // Expected byte number idx of a request starting at word address base
  function automatic logic [7:0] ref_byte(input int base, input int idx);
    logic [127:0] w;
    int lane;
    w    = mem[(base + idx / 16) % 1024];
    lane = lane_map[idx % 16];
    return w[127 - 8*lane -: 8];
  endfunction

  // Present a start pulse at the current negedge (cycle 0 of the request)
  task automatic do_start(input int base, input int n);
    bus.start     = 1'b1;
    bus.base_addr = base[9:0];
    bus.num_words = n[9:0];
  endtask

  // Step cycles after a start, record reads/bytes/done, drive random out_ready
  task automatic collect(input int max_cyc, input int low_pct, input bit restart_mid);
    int cyc = 0;
    int post = -1;
    bit pv = 0, pr = 0;
    logic [7:0] pb = '0;
    logic [3:0] po = '0;
    rd_addr_q.delete(); rd_cyc_q.delete(); rd_acc_q.delete();
    byte_q.delete(); off_q.delete(); acc_cyc_q.delete(); done_cyc_q.delete();
    first_valid = -1; valid_cycles = 0; stall_viol = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (restart_mid && cyc == 10) do_start(32'h2A0, 5);
      if (pv && !pr) begin
        if (!bus.out_valid || bus.out_byte !== pb || bus.out_offset !== po) stall_viol++;
      end
      if (bus.sram_rd_en) begin
        rd_addr_q.push_back(int'(bus.sram_raddr));
        rd_cyc_q.push_back(cyc);
        rd_acc_q.push_back(byte_q.size());
      end
      if (bus.done) done_cyc_q.push_back(cyc);
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
      end
      bus.out_ready = ($urandom_range(99) >= low_pct);
      if (bus.out_valid && bus.out_ready) begin
        byte_q.push_back(bus.out_byte);
        off_q.push_back(int'(bus.out_offset));
        acc_cyc_q.push_back(cyc);
      end
      pv = bus.out_valid; pr = bus.out_ready; pb = bus.out_byte; po = bus.out_offset;
      if (done_cyc_q.size() > 0 && post < 0) post = cyc;
      if (post >= 0 && cyc >= post + 3) break;
    end
    bus.out_ready = 1'b0;
    $display("txn: reads=%0d bytes=%0d dones=%0d first_valid=%0d cycles=%0d",
             rd_addr_q.size(), byte_q.size(), done_cyc_q.size(), first_valid, cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0", bus.sram_rd_en); end
    n_checks++; if (bus.sram_raddr !== 10'd0) begin n_fail++; $display("FAIL reset_raddr got=%h want=0", bus.sram_raddr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (bus.out_byte !== 8'd0) begin n_fail++; $display("FAIL reset_byte got=%h want=0", bus.out_byte); end
    n_checks++; if (bus.out_offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset got=%0d want=0", bus.out_offset); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [16] = '{8'h00, 8'h44, 8'h11, 8'h55, 8'h88, 8'hCC, 8'h99, 8'hDD,
                               8'h22, 8'h66, 8'h33, 8'h77, 8'hAA, 8'hEE, 8'hBB, 8'hFF};
    mem[5] = 128'h00112233445566778899AABBCCDDEEFF;
    do_start(5, 1);
    collect(60, 0, 0);
    n_checks++; if (rd_addr_q.size() !== 1) begin n_fail++; $display("FAIL single_nreads got=%0d want=1", rd_addr_q.size()); end
    if (rd_addr_q.size() > 0) begin
      n_checks++; if (rd_addr_q[0] !== 5) begin n_fail++; $display("FAIL single_addr got=%h want=005", rd_addr_q[0]); end
    end
    n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL single_first_valid got=%0d want=3", first_valid); end
    n_checks++; if (byte_q.size() !== 16) begin n_fail++; $display("FAIL single_nbytes got=%0d want=16", byte_q.size()); end
    for (int i = 0; i < 16 && i < byte_q.size(); i++) begin
      n_checks++;
      if (byte_q[i] !== exp_b[i] || off_q[i] !== i) begin
        n_fail++;
        $display("FAIL single_byte[%0d] got=%h/off%0d want=%h/off%0d", i, byte_q[i], off_q[i], exp_b[i], i);
      end
    end
    n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL single_ndone got=%0d want=1", done_cyc_q.size()); end
    if (done_cyc_q.size() > 0 && acc_cyc_q.size() > 0) begin
      n_checks++;
      if (done_cyc_q[0] !== acc_cyc_q[acc_cyc_q.size()-1] + 1) begin
        n_fail++; $display("FAIL single_done_cyc got=%0d want=%0d", done_cyc_q[0], acc_cyc_q[acc_cyc_q.size()-1] + 1);
      end
    end
  endtask

  task automatic test_addr_wrap();
    int exp_addr [3] = '{32'h3FE, 32'h3FF, 32'h000};
    int exp_cyc  [3] = '{1, 19, 37};
    do_start(32'h3FE, 3);
    collect(100, 0, 0);
    n_checks++; if (rd_addr_q.size() !== 3) begin n_fail++; $display("FAIL wrap_nreads got=%0d want=3", rd_addr_q.size()); end
    for (int i = 0; i < 3 && i < rd_addr_q.size(); i++) begin
      n_checks++;
      if (rd_addr_q[i] !== exp_addr[i] || rd_cyc_q[i] !== exp_cyc[i]) begin
        n_fail++; $display("FAIL wrap_read[%0d] got=%h@%0d want=%h@%0d", i, rd_addr_q[i], rd_cyc_q[i], exp_addr[i], exp_cyc[i]);
      end
    end
    n_checks++; if (byte_q.size() !== 48) begin n_fail++; $display("FAIL wrap_nbytes got=%0d want=48", byte_q.size()); end
    for (int i = 0; i < byte_q.size() && i < 48; i++) begin
      n_checks++;
      if (byte_q[i] !== ref_byte(32'h3FE, i) || off_q[i] !== i % 16) begin
        n_fail++; $display("FAIL wrap_byte[%0d] got=%h/off%0d want=%h/off%0d", i, byte_q[i], off_q[i], ref_byte(32'h3FE, i), i % 16);
      end
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 55) begin
      n_fail++; $display("FAIL wrap_done got=%0d pulses first@%0d want=1 pulse @55", done_cyc_q.size(),
                         done_cyc_q.size() > 0 ? done_cyc_q[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    int base = $urandom_range(1023);
    for (int i = 0; i < 4; i++) mem[(base + i) % 1024] = {$urandom, $urandom, $urandom, $urandom};
    do_start(base, 4);
    collect(1000, 30, 0);
    n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable got=%0d violations want=0", stall_viol); end
    n_checks++; if (byte_q.size() !== 64) begin n_fail++; $display("FAIL bp_nbytes got=%0d want=64", byte_q.size()); end
    for (int i = 0; i < byte_q.size() && i < 64; i++) begin
      n_checks++;
      if (byte_q[i] !== ref_byte(base, i) || off_q[i] !== i % 16) begin
        n_fail++; $display("FAIL bp_byte[%0d] got=%h/off%0d want=%h/off%0d", i, byte_q[i], off_q[i], ref_byte(base, i), i % 16);
      end
    end
    n_checks++; if (rd_addr_q.size() !== 4) begin n_fail++; $display("FAIL bp_nreads got=%0d want=4", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
      n_checks++;
      if (rd_acc_q[i] !== 16 * i || rd_addr_q[i] !== (base + i) % 1024) begin
        n_fail++; $display("FAIL bp_read[%0d] got=%h after %0d bytes want=%h after %0d bytes",
                           i, rd_addr_q[i], rd_acc_q[i], (base + i) % 1024, 16 * i);
      end
    end
    n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL bp_ndone got=%0d want=1", done_cyc_q.size()); end
  endtask

  task automatic test_zero_words();
    do_start($urandom_range(1023), 0);
    collect(20, 0, 0);
    n_checks++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== 1) begin
      n_fail++; $display("FAIL zero_done got=%0d pulses first@%0d want=1 pulse @1", done_cyc_q.size(),
                         done_cyc_q.size() > 0 ? done_cyc_q[0] : -1);
    end
    n_checks++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL zero_reads got=%0d want=0", rd_addr_q.size()); end
    n_checks++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL zero_valid got=%0d cycles want=0", valid_cycles); end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 2; i++) mem[32'h100 + i] = {$urandom, $urandom, $urandom, $urandom};
    do_start(32'h100, 2);
    collect(200, 0, 1);
    n_checks++; if (rd_addr_q.size() !== 2) begin n_fail++; $display("FAIL restart_nreads got=%0d want=2", rd_addr_q.size()); end
    n_checks++; if (byte_q.size() !== 32) begin n_fail++; $display("FAIL restart_nbytes got=%0d want=32", byte_q.size()); end
    for (int i = 0; i < byte_q.size() && i < 32; i++) begin
      n_checks++;
      if (byte_q[i] !== ref_byte(32'h100, i)) begin
        n_fail++; $display("FAIL restart_byte[%0d] got=%h want=%h", i, byte_q[i], ref_byte(32'h100, i));
      end
    end
    n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL restart_ndone got=%0d want=1", done_cyc_q.size()); end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    mem[32'h200] = {$urandom, $urandom, $urandom, $urandom};
    mem[32'h201] = {$urandom, $urandom, $urandom, $urandom};
    mem[32'h010] = {$urandom, $urandom, $urandom, $urandom};
    do_start(32'h200, 2);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.out_valid && bus.out_offset == 4'd7) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL arst_reach_offset7 got=not reached want=reached"); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.sram_rd_en, bus.sram_raddr, bus.out_valid, bus.out_byte, bus.out_offset, bus.busy, bus.done} !== '0) begin
      n_fail++; $display("FAIL arst_outputs got=rd%b addr%h v%b b%h o%0d busy%b done%b want=all 0",
                         bus.sram_rd_en, bus.sram_raddr, bus.out_valid, bus.out_byte, bus.out_offset, bus.busy, bus.done);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(32'h010, 1);
    collect(60, 0, 0);
    n_checks++;
    if (rd_addr_q.size() < 1 || rd_addr_q[0] !== 32'h010) begin
      n_fail++; $display("FAIL arst_new_read got=%0d reads first=%h want=read at 010", rd_addr_q.size(),
                         rd_addr_q.size() > 0 ? rd_addr_q[0] : -1);
    end
    n_checks++;
    if (byte_q.size() < 1 || off_q[0] !== 0 || byte_q[0] !== ref_byte(32'h010, 0)) begin
      n_fail++; $display("FAIL arst_first_byte got=%0d bytes first=%h/off%0d want=%h/off0", byte_q.size(),
                         byte_q.size() > 0 ? byte_q[0] : 8'h00, off_q.size() > 0 ? off_q[0] : -1, ref_byte(32'h010, 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single_word();
    test_addr_wrap();
    test_backpressure();
    test_zero_words();
    test_restart_ignored();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
